// File: rtl/npc_pkg.sv
// Shared core definitions: datapath width, reset vector, canonical NOP and
// the fetch-stage state encoding. Decode pulls XLEN from here as well.
package npc_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ifu_pc_gen.sv
// Architectural PC register: holds, steps by one word, or loads a redirect
// target. A redirect always wins over a step in the same cycle, and the
// target's byte-offset bits are discarded so the PC stays word aligned.
module ifu_pc_gen #(
  parameter int unsigned     XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);
  import npc_pkg::*;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next PC select: redirect target (aligned), sequential word, or hold
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (advance) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // PC register, loads the reset vector asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage. Issues one word fetch at a time, registers the
// response with its PC and fault flag, and offers it to decode.
//
// Handshakes: a transfer on imem_req_* or inst_* happens at a rising edge
// where valid && ready; valid is never gated by ready. The decode payload
// (inst, inst_pc, inst_err) is held while inst_valid && !inst_ready unless a
// redirect discards it. imem_req_addr may change while imem_req_valid is high
// only when a redirect lands before the request is accepted. imem_rsp_valid
// has no ready: a response is always taken and is only expected in WAIT.
module ifu_fetch #(
  parameter int unsigned     XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err
);
  import npc_pkg::*;

  ifu_state_t      state_q, state_d;
  logic            kill_q, kill_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_err_q, inst_err_d;
  logic [XLEN-1:0] pc;
  logic            advance;
  logic            capture;

  ifu_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (advance),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  // FSM state and the "outstanding fetch is stale" flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // Next state; a redirect marks any in-flight fetch stale or drops held data
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      FETCH: begin
        if (imem_req_ready) begin
          state_d = WAIT;
          kill_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          kill_d  = 1'b0;
          state_d = (kill_q || redirect_valid) ? FETCH : OUT;
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid || inst_ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
        kill_d  = 1'b0;
      end
    endcase
  end

  // FSM outputs: request side, decode valid, PC step and capture strobes
  always_comb begin
    imem_req_valid = (state_q == FETCH);
    imem_req_addr  = {pc[XLEN-1:2], 2'b00};
    inst_valid     = (state_q == OUT);
    advance        = (state_q == OUT) && inst_ready && !redirect_valid;
    capture        = (state_q == WAIT) && imem_rsp_valid && !kill_q && !redirect_valid;
  end

  // Next value of the decode-facing instruction register
  always_comb begin
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    if (capture) begin
      inst_d     = imem_rsp_data;
      inst_pc_d  = pc;
      inst_err_d = imem_rsp_err;
    end
  end

  // Instruction register, resets to a NOP at PC 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q     <= NOP_INST;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

  assign inst     = inst_q;
  assign inst_pc  = inst_pc_q;
  assign inst_err = inst_err_q;

  a_req_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));

  a_inst_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (inst_valid && !inst_ready && !redirect_valid) |=>
      (inst_valid && $stable(inst) && $stable(inst_pc) && $stable(inst_err)));

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (state_q == WAIT));

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: instruction memory model, architectural PC model,
// directed scenarios followed by a randomized run.
module tb_ifu_fetch;
  import npc_pkg::*;

  localparam int W = 65;  // {err, pc, data}
  localparam logic [31:0] BP_INST = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  // Clock
  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err)
  );

  // Counters and scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: architectural PC plus one-deep memory
  logic [31:0] model_pc;
  bit          outstanding;
  int          rsp_cnt;
  logic [31:0] out_data;
  bit          out_err;

  // Stimulus knobs and one-shot overrides
  int          p_rdy = 100, k_min = 1, k_max = 1, p_ir = 100, p_red = 0, p_err = 0;
  bit          f_red = 1'b0;
  logic [31:0] f_tgt = 32'h0;
  int          f_ir = -1;
  bit          f_data_en = 1'b0;
  logic [31:0] f_data = 32'h0;
  bit          chk_space = 1'b0;

  // Observations of the last cycle
  bit          ob_acc, ob_rv, ob_iv;
  logic [31:0] ob_addr;
  int          cyc = 0;
  int          last_acc_cyc = -1;
  int          n_iv_seen = 0;
  int          n_hs = 0;
  logic [31:0] hs_pc = 32'h0;
  bit          hs_err = 1'b0;

  // Monitor history
  bit          prev_iv, prev_ir, prev_red, prev_live;
  logic [31:0] prev_inst, prev_pc;
  bit          prev_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h0000_0033;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFFC;
    else t = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
    t[1:0] = 2'($urandom_range(0, 3));
    return t;
  endfunction

  task automatic clear_env();
    outstanding    = 1'b0;
    rsp_cnt        = 0;
    exp_q.delete();
    model_pc       = RESET_PC;
    last_acc_cyc   = -1;
    f_red          = 1'b0;
    f_ir           = -1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
  endtask

  // One clock: drive inputs after the rising edge, observe at the falling edge
  task cycle();
    @(posedge clk);
    #1;
    if (outstanding && rsp_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = out_data;
      imem_rsp_err   = out_err;
      outstanding    = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'($urandom_range(0, 1));
      if (outstanding) rsp_cnt--;
    end
    imem_req_ready = ($urandom_range(0, 99) < p_rdy);
    if (f_red) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_tgt;
      f_red          = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(0, 99) < p_red);
      redirect_pc    = rand_tgt();
    end
    if (f_ir >= 0) begin
      inst_ready = f_ir[0];
      f_ir       = -1;
    end else begin
      inst_ready = ($urandom_range(0, 99) < p_ir);
    end

    @(negedge clk);
    ob_rv   = imem_req_valid;
    ob_acc  = imem_req_valid && imem_req_ready;
    ob_addr = imem_req_addr;
    ob_iv   = inst_valid;
    if (ob_iv) n_iv_seen++;
    if (imem_req_valid) check("one_outstanding", {31'h0, outstanding || inst_valid}, 0);
    if (ob_acc) begin
      check("req_addr", ob_addr, model_pc);
      if (chk_space && last_acc_cyc >= 0) check("req_spacing", cyc - last_acc_cyc, 3);
      last_acc_cyc = cyc;
      outstanding  = 1'b1;
      rsp_cnt      = $urandom_range(k_min, k_max) - 1;
      out_data     = f_data_en ? f_data : mem_word(ob_addr);
      f_data_en    = 1'b0;
      out_err      = ($urandom_range(0, 99) < p_err);
      if (!redirect_valid) exp_q.push_back({out_err, model_pc, out_data});
    end
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = redirect_pc & ~32'h3;
    end else if (inst_valid && inst_ready) begin
      model_pc = model_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic wait_acc(input string name, input logic [31:0] exp_addr);
    int n = 0;
    do begin cycle(); n++; end while (!ob_acc && n < 60);
    if (!ob_acc) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no request accepted in 60 cycles, required addr %0h", name, exp_addr);
    end else begin
      check(name, ob_addr, exp_addr);
    end
  endtask

  task automatic wait_iv(input string name);
    int n = 0;
    do begin cycle(); n++; end while (!ob_iv && n < 60);
    if (!ob_iv) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: inst_valid 0 for 60 cycles, required 1", name);
    end
  endtask

  task do_reset();
    rst_n = 1'b0;
    clear_env();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, NOP_INST);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_err", inst_err, 0);
    rst_n = 1'b1;
    cycle();
    check("rst_first_req", {ob_rv, ob_addr}, {1'b1, RESET_PC});
  endtask

  // Scoreboard monitor: handshake data, latency and hold checks
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (!rst_n) begin
      prev_iv = 0; prev_ir = 0; prev_red = 0; prev_live = 0;
    end else begin
      check("inst_valid_latency", {31'h0, inst_valid && !prev_iv}, {31'h0, prev_live});
      if (prev_iv && !prev_ir && !prev_red) begin
        check("hold_valid", inst_valid, 1);
        check("hold_inst", inst, prev_inst);
        check("hold_pc", inst_pc, prev_pc);
        check("hold_err", inst_err, prev_err);
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL hs_unexpected: actual inst_pc %0h consumed, required none", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("hs_inst", inst, e[31:0]);
          check("hs_pc", inst_pc, e[63:32]);
          check("hs_err", inst_err, e[64]);
          hs_pc  = inst_pc;
          hs_err = inst_err;
        end
      end
      prev_iv   = inst_valid;
      prev_ir   = inst_ready;
      prev_red  = redirect_valid;
      prev_inst = inst;
      prev_pc   = inst_pc;
      prev_err  = inst_err;
      prev_live = imem_rsp_valid && !redirect_valid && (exp_q.size() > 0);
    end
  end

  initial begin
    int iv0, hs0;
    clear_env();
    #2;
    do_reset();

    // Straight-line fetch, one instruction every 3 cycles
    chk_space = 1'b1;
    wait_acc("a_req1", 32'h8000_0004);
    wait_acc("a_req2", 32'h8000_0008);
    wait_acc("a_req3", 32'h8000_000C);
    chk_space = 1'b0;
    check("a_last_pc", hs_pc, 32'h8000_0008);
    check("a_last_err", hs_err, 0);

    // Decode backpressure
    p_ir = 0; f_data_en = 1'b1; f_data = BP_INST;
    do_reset();
    wait_iv("b_iv");
    check("b_inst", inst, BP_INST);
    check("b_inst_pc", inst_pc, 32'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("b_held", ob_iv, 1);
      check("b_no_req", ob_rv, 0);
    end
    check("b_inst_after", inst, BP_INST);
    k_min = 3; k_max = 3; p_ir = 100;
    wait_acc("b_next_req", 32'h8000_0004);

    // Redirect while waiting, response two cycles later
    k_min = 1; k_max = 1;
    f_red = 1'b1; f_tgt = 32'h8000_0103;
    iv0 = n_iv_seen;
    cycle();
    wait_acc("c_req", 32'h8000_0100);
    check("c_no_inst", n_iv_seen - iv0, 0);

    // Redirect with same-cycle response, then redirect in OUT with inst_ready
    f_red = 1'b1; f_tgt = 32'h8000_0200; p_ir = 0;
    iv0 = n_iv_seen;
    cycle();
    wait_acc("d_req", 32'h8000_0200);
    check("d_no_inst", n_iv_seen - iv0, 0);
    wait_iv("d_iv");
    hs0 = n_hs;
    f_red = 1'b1; f_tgt = 32'h8000_0200; f_ir = 1;
    cycle();
    p_ir = 100;
    wait_acc("d_req_after_out", 32'h8000_0200);
    check("d_no_consume", n_hs - hs0, 0);

    // Fault passes through, then PC wrap
    p_err = 100;
    do_reset();
    p_err = 0;
    wait_acc("e_req", 32'h8000_0004);
    check("e_fault_pc", hs_pc, 32'h8000_0000);
    check("e_fault_err", hs_err, 1);
    p_ir = 0;
    wait_iv("e_iv");
    f_red = 1'b1; f_tgt = 32'hFFFF_FFFC;
    cycle();
    p_ir = 100;
    wait_acc("e_req_top", 32'hFFFF_FFFC);
    wait_acc("e_req_wrap", 32'h0000_0000);
    check("e_top_pc", hs_pc, 32'hFFFF_FFFC);

    // Asynchronous reset while waiting for a response
    k_min = 5; k_max = 5;
    wait_acc("f_req", 32'h0000_0004);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("f_async_inst_valid", inst_valid, 0);
    check("f_async_req_valid", imem_req_valid, 1);
    check("f_async_pc", imem_req_addr, RESET_PC);
    check("f_async_inst", inst, NOP_INST);
    clear_env();
    f_data_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("f_post_req", {ob_rv, ob_addr}, {1'b1, RESET_PC});
    wait_iv("f_iv");
    check("f_inst_pc", inst_pc, RESET_PC);

    // Randomized traffic
    hs0 = n_hs;
    p_rdy = 60; k_min = 1; k_max = 4; p_ir = 60; p_red = 8; p_err = 20;
    for (int i = 0; i < 3000; i++) cycle();
    p_rdy = 100; k_min = 1; k_max = 1; p_ir = 100; p_red = 0;
    repeat (20) cycle();
    check("g_activity", {31'h0, n_hs > hs0 + 100}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
